tge_tx_mux: RTL and testbench

- Multi-channel transmit aggregator in front of tge_tx, in the application clock domain.
- Accepts N_CH independent 64-bit UDP frame streams, each with its own destination IP/port.
- Buffers each stream store-and-forward with commit/rollback, so partial frames are never forwarded.
- Issues complete frames one at a time to the single tge_tx application interface, using round-robin frame-level arbitration.

---
 rtl/tge_tx_mux_pkg.sv | 39 +++
 rtl/tge_tx_mux_chan.sv | 129 ++++++++++++
 rtl/tge_tx_mux.sv | 220 ++++++++++++++++++++++
 tb/tb_tge_tx_mux.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tge_tx_mux_pkg.sv
// -----------------------------------------------------------------------------
// tge_tx_mux_pkg
// Shared types and helpers for the multi-channel transmit aggregator.
//   arb_state_e : frame arbiter states (IDLE, GRANT, SEND)
//   wr_state_e  : per-channel write-side states (ACCEPT, DISCARD)
//   desc_t      : frame descriptor {ip, port} captured with the eof word
//   clog2()     : ceiling log2, used to size pointers and indices
// -----------------------------------------------------------------------------
package tge_tx_mux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2
    } arb_state_e;

    typedef enum logic {
        ACCEPT  = 1'b0,
        DISCARD = 1'b1
    } wr_state_e;

    typedef struct packed {
        logic [31:0] ip;
        logic [15:0] port;
    } desc_t;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/tge_tx_mux_chan.sv
// -----------------------------------------------------------------------------
// tge_tx_mux_chan
// One input channel of the aggregator: store-and-forward data RAM with
// commit/rollback write pointers, descriptor FIFO and discard FSM.
// Readers only ever see committed (complete) frames.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   valid, eof, data    incoming word stream
//   dest_ip, dest_port  destination, sampled with the eof word
//   afull               free words < AFULL_MARGIN or descriptor FIFO full
//   overflow            one-cycle pulse when a frame is dropped
//   frame_avail         at least one committed frame not yet fully sent
//   rd_en / rd_data     RAM read request, {eof, data} valid the next cycle
//   desc_pop / desc     descriptor FIFO head and pop strobe
//   frame_done          arbiter finished sending one frame of this channel
//
// FRM_DEPTH must be a power of two >= 2; DEPTH a power of two >= 16.
// -----------------------------------------------------------------------------
module tge_tx_mux_chan
    import tge_tx_mux_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int DEPTH        = 512,
    parameter int FRM_DEPTH    = 16,
    parameter int AFULL_MARGIN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic              eof,
    input  logic [DATA_W-1:0] data,
    input  logic [31:0]       dest_ip,
    input  logic [15:0]       dest_port,
    output logic              afull,
    output logic              overflow,
    output logic              frame_avail,
    input  logic              rd_en,
    output logic [DATA_W:0]   rd_data,
    input  logic              desc_pop,
    output desc_t             desc,
    input  logic              frame_done
);

    localparam int AW  = clog2(DEPTH);
    localparam int PW  = AW + 1;          // extra wrap bit
    localparam int FAW = clog2(FRM_DEPTH);
    localparam int FPW = FAW + 1;

    logic [DATA_W:0] ram [DEPTH];
    desc_t           desc_mem [FRM_DEPTH];
    logic [DATA_W:0] rd_data_reg;

    logic [PW-1:0]   wr_ptr_reg, wr_cmt_reg, rd_ptr_reg;
    logic [FPW-1:0]  desc_wr_reg, desc_rd_reg, frm_cnt_reg;
    wr_state_e       wstate_reg, wstate_next;

    logic [PW-1:0]   used_words, free_words;
    logic            data_full, desc_full, drop, accept_word, commit;

    // Fullness counts uncommitted words too: they occupy RAM until rollback.
    assign used_words  = wr_ptr_reg - rd_ptr_reg;
    assign free_words  = PW'(DEPTH) - used_words;
    assign data_full   = (used_words == PW'(DEPTH));
    assign desc_full   = ((desc_wr_reg - desc_rd_reg) == FPW'(FRM_DEPTH));

    assign drop        = valid && (wstate_reg == ACCEPT) && (data_full || (eof && desc_full));
    assign accept_word = valid && (wstate_reg == ACCEPT) && !drop;
    assign commit      = accept_word && eof;

    assign afull       = (free_words < PW'(AFULL_MARGIN)) || desc_full;
    assign overflow    = drop;
    assign frame_avail = (frm_cnt_reg != '0);
    assign rd_data     = rd_data_reg;
    assign desc        = desc_mem[desc_rd_reg[FAW-1:0]];

    // A dropped word that is itself the eof already ends the bad frame,
    // so there is nothing left to discard.
    always_comb begin
        wstate_next = wstate_reg;
        case (wstate_reg)
            ACCEPT:  if (drop && !eof) wstate_next = DISCARD;
            DISCARD: if (valid && eof) wstate_next = ACCEPT;
            default: wstate_next = ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_reg  <= ACCEPT;
            wr_ptr_reg  <= '0;
            wr_cmt_reg  <= '0;
            rd_ptr_reg  <= '0;
            desc_wr_reg <= '0;
            desc_rd_reg <= '0;
            frm_cnt_reg <= '0;
        end else begin
            wstate_reg <= wstate_next;
            if (drop)
                wr_ptr_reg <= wr_cmt_reg;
            else if (accept_word)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (commit) begin
                wr_cmt_reg  <= wr_ptr_reg + 1'b1;
                desc_wr_reg <= desc_wr_reg + 1'b1;
            end
            if (rd_en)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (desc_pop)
                desc_rd_reg <= desc_rd_reg + 1'b1;
            case ({commit, frame_done})
                2'b10:   frm_cnt_reg <= frm_cnt_reg + 1'b1;
                2'b01:   frm_cnt_reg <= frm_cnt_reg - 1'b1;
                default: frm_cnt_reg <= frm_cnt_reg;
            endcase
        end
    end

    // Storage: no reset so the arrays map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (accept_word)
            ram[wr_ptr_reg[AW-1:0]] <= {eof, data};
        if (rd_en)
            rd_data_reg <= ram[rd_ptr_reg[AW-1:0]];
        if (commit)
            desc_mem[desc_wr_reg[FAW-1:0]] <= '{ip: dest_ip, port: dest_port};
    end

endmodule

// File: rtl/tge_tx_mux.sv
// -----------------------------------------------------------------------------
// tge_tx_mux
// Aggregates N_CH store-and-forward UDP frame streams onto the single tge_tx
// application interface, one complete frame at a time, round-robin.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   ch_valid/ch_eof/ch_data       per-channel word streams (packed per channel)
//   ch_dest_ip/ch_dest_port       per-channel destination, sampled with eof
//   ch_afull, ch_overflow         per-channel backpressure / drop pulse
//   out_valid/out_eof/out_data    to tge_tx tx_valid/tx_end_of_frame/tx_data
//   out_dest_ip/out_dest_port     held for the whole frame
//   out_afull                     from tge_tx tx_afull
//
// Optional: define TGE_TX_MUX_STATS_EN to add per-channel saturating
// frames-sent / frames-dropped counters read through stat_sel, stat_sent,
// stat_drop (registered one cycle after stat_sel).
// -----------------------------------------------------------------------------
module tge_tx_mux
    import tge_tx_mux_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int DATA_W       = 64,
    parameter int DEPTH        = 512,
    parameter int FRM_DEPTH    = 16,
    parameter int AFULL_MARGIN = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        ch_valid,
    input  logic [N_CH-1:0]        ch_eof,
    input  logic [N_CH*DATA_W-1:0] ch_data,
    input  logic [N_CH*32-1:0]     ch_dest_ip,
    input  logic [N_CH*16-1:0]     ch_dest_port,
    output logic [N_CH-1:0]        ch_afull,
    output logic [N_CH-1:0]        ch_overflow,
    output logic                   out_valid,
    output logic                   out_eof,
    output logic [DATA_W-1:0]      out_data,
    output logic [31:0]            out_dest_ip,
    output logic [15:0]            out_dest_port,
`ifdef TGE_TX_MUX_STATS_EN
    input  logic [3:0]             stat_sel,
    output logic [31:0]            stat_sent,
    output logic [31:0]            stat_drop,
`endif
    input  logic                   out_afull
);

    localparam int CH_W = (N_CH > 1) ? clog2(N_CH) : 1;

    logic [N_CH-1:0]           frame_avail, rd_en, desc_pop, frame_done;
    logic [N_CH-1:0][DATA_W:0] rd_data_all;
    desc_t [N_CH-1:0]          desc_all;

    arb_state_e      state_reg, state_next;
    logic [CH_W-1:0] gnt_reg, rr_reg, win;
    logic            found;
    int              sel_idx;
    logic            issue_rd, frame_end;
    logic            out_valid_reg;
    logic [31:0]     ip_reg;
    logic [15:0]     port_reg;
    logic [DATA_W:0] cur_word;
    logic            cur_last;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_chan
            tge_tx_mux_chan #(
                .DATA_W       (DATA_W),
                .DEPTH        (DEPTH),
                .FRM_DEPTH    (FRM_DEPTH),
                .AFULL_MARGIN (AFULL_MARGIN)
            ) u_chan (
                .clk         (clk),
                .rst_n       (rst_n),
                .valid       (ch_valid[gi]),
                .eof         (ch_eof[gi]),
                .data        (ch_data[gi*DATA_W +: DATA_W]),
                .dest_ip     (ch_dest_ip[gi*32 +: 32]),
                .dest_port   (ch_dest_port[gi*16 +: 16]),
                .afull       (ch_afull[gi]),
                .overflow    (ch_overflow[gi]),
                .frame_avail (frame_avail[gi]),
                .rd_en       (rd_en[gi]),
                .rd_data     (rd_data_all[gi]),
                .desc_pop    (desc_pop[gi]),
                .desc        (desc_all[gi]),
                .frame_done  (frame_done[gi])
            );
            assign rd_en[gi]      = issue_rd && (gnt_reg == CH_W'(gi));
            assign desc_pop[gi]   = (state_reg == GRANT) && (gnt_reg == CH_W'(gi));
            assign frame_done[gi] = frame_end && (gnt_reg == CH_W'(gi));
        end
    endgenerate

    // The RAM read register of the granted channel is the output data
    // register; out_valid_reg tracks which of its contents are fresh.
    assign cur_word = rd_data_all[gnt_reg];
    assign cur_last = cur_word[DATA_W];

    // Round robin: first channel with a committed frame after rr_reg.
    always_comb begin
        found   = 1'b0;
        win     = rr_reg;
        sel_idx = 0;
        for (int i = 1; i <= N_CH; i++) begin
            sel_idx = int'(rr_reg) + i;
            if (sel_idx >= N_CH)
                sel_idx = sel_idx - N_CH;
            if (!found && frame_avail[sel_idx]) begin
                found = 1'b1;
                win   = CH_W'(sel_idx);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        issue_rd   = 1'b0;
        frame_end  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!out_afull && found)
                    state_next = GRANT;
            end
            GRANT: begin
                issue_rd   = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                // During a bubble the read register still holds an already
                // presented non-eof word, so gate the eof test with valid.
                if (out_valid_reg && cur_last) begin
                    frame_end  = 1'b1;
                    state_next = IDLE;
                end else if (!out_afull) begin
                    issue_rd = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            rr_reg        <= CH_W'(N_CH - 1);
            out_valid_reg <= 1'b0;
            ip_reg        <= '0;
            port_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= issue_rd;
            if (state_reg == IDLE && state_next == GRANT) begin
                gnt_reg <= win;
                rr_reg  <= win;
            end
            if (state_reg == GRANT) begin
                ip_reg   <= desc_all[gnt_reg].ip;
                port_reg <= desc_all[gnt_reg].port;
            end
        end
    end

    assign out_valid     = out_valid_reg;
    assign out_eof       = out_valid_reg && cur_last;
    assign out_data      = out_valid_reg ? cur_word[DATA_W-1:0] : '0;
    assign out_dest_ip   = ip_reg;
    assign out_dest_port = port_reg;

`ifdef TGE_TX_MUX_STATS_EN
    logic [N_CH-1:0][31:0] sent_cnt_reg, drop_cnt_reg;
    logic [31:0]           sent_sel, drop_sel;
    logic [31:0]           stat_sent_reg, stat_drop_reg;

    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_stats
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sent_cnt_reg[gi] <= '0;
                    drop_cnt_reg[gi] <= '0;
                end else begin
                    if (frame_done[gi] && (sent_cnt_reg[gi] != '1))
                        sent_cnt_reg[gi] <= sent_cnt_reg[gi] + 1'b1;
                    if (ch_overflow[gi] && (drop_cnt_reg[gi] != '1))
                        drop_cnt_reg[gi] <= drop_cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin
        sent_sel = '0;
        drop_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (stat_sel == 4'(i)) begin
                sent_sel = sent_cnt_reg[i];
                drop_sel = drop_cnt_reg[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_sent_reg <= '0;
            stat_drop_reg <= '0;
        end else begin
            stat_sent_reg <= sent_sel;
            stat_drop_reg <= drop_sel;
        end
    end

    assign stat_sent = stat_sent_reg;
    assign stat_drop = stat_drop_reg;
`endif

endmodule

// File: tb/tb_tge_tx_mux.sv
// -----------------------------------------------------------------------------
// tb_tge_tx_mux
// Directed stimulus with a scoreboard: expected output words are queued when
// frames are issued; a negedge monitor pops and compares every out_valid word.
// -----------------------------------------------------------------------------
module tb_tge_tx_mux;

    localparam int N_CH         = 4;
    localparam int DATA_W       = 64;
    localparam int DEPTH        = 16;
    localparam int FRM_DEPTH    = 16;
    localparam int AFULL_MARGIN = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_CH-1:0]        ch_valid;
    logic [N_CH-1:0]        ch_eof;
    logic [N_CH*DATA_W-1:0] ch_data;
    logic [N_CH*32-1:0]     ch_dest_ip;
    logic [N_CH*16-1:0]     ch_dest_port;
    logic [N_CH-1:0]        ch_afull;
    logic [N_CH-1:0]        ch_overflow;
    logic                   out_valid;
    logic                   out_eof;
    logic [DATA_W-1:0]      out_data;
    logic [31:0]            out_dest_ip;
    logic [15:0]            out_dest_port;
    logic                   out_afull;

    tge_tx_mux #(
        .N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .FRM_DEPTH(FRM_DEPTH), .AFULL_MARGIN(AFULL_MARGIN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ch_valid      (ch_valid),
        .ch_eof        (ch_eof),
        .ch_data       (ch_data),
        .ch_dest_ip    (ch_dest_ip),
        .ch_dest_port  (ch_dest_port),
        .ch_afull      (ch_afull),
        .ch_overflow   (ch_overflow),
        .out_valid     (out_valid),
        .out_eof       (out_eof),
        .out_data      (out_data),
        .out_dest_ip   (out_dest_ip),
        .out_dest_port (out_dest_port),
        .out_afull     (out_afull)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        eof;
        logic [31:0] ip;
        logic [15:0] port;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   eof_seen = 0;
    int   bubbles = 0;
    bit   in_frame = 0;
    int   first_valid_cyc = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_word(input logic [63:0] d, input logic e,
                               input logic [31:0] ip, input logic [15:0] port);
        exp_t x;
        x.data = d; x.eof = e; x.ip = ip; x.port = port;
        sb_q.push_back(x);
    endtask

    task automatic drive_word(input int ch, input logic [63:0] d, input logic e,
                              input logic [31:0] ip, input logic [15:0] port);
        ch_valid[ch]            = 1'b1;
        ch_eof[ch]              = e;
        ch_data[ch*64 +: 64]    = d;
        ch_dest_ip[ch*32 +: 32] = ip;
        ch_dest_port[ch*16 +: 16] = port;
        @(posedge clk); #1;
        ch_valid = '0;
        ch_eof   = '0;
    endtask

    task automatic send_frame(input int ch, input int n, input logic [63:0] base,
                              input logic [31:0] ip, input logic [15:0] port);
        for (int w = 0; w < n; w++)
            expect_word(base + 64'(w), (w == n - 1), ip, port);
        for (int w = 0; w < n; w++)
            drive_word(ch, base + 64'(w), (w == n - 1), ip, port);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || in_frame) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", 64'(sb_q.size()), 64'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_out_valid", 64'(out_valid), 64'd1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard monitor.
    initial begin
        exp_t e;
        bit   prev_eof;
        prev_eof = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 0;
                prev_eof = 0;
            end else begin
                if (prev_eof) begin
                    checks++;
                    if (out_valid) begin
                        errors++;
                        $display("FAIL eof_gap actual out_valid=1 required out_valid=0 after out_eof");
                    end
                end
                if (out_valid) begin
                    if (first_valid_cyc < 0)
                        first_valid_cyc = cyc;
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word actual data=%h eof=%0d required no output",
                                 out_data, out_eof);
                    end else begin
                        e = sb_q.pop_front();
                        if (out_data !== e.data || out_eof !== e.eof ||
                            out_dest_ip !== e.ip || out_dest_port !== e.port) begin
                            errors++;
                            $display("FAIL out_word actual data=%h eof=%0d ip=%h port=%h required data=%h eof=%0d ip=%h port=%h",
                                     out_data, out_eof, out_dest_ip, out_dest_port,
                                     e.data, e.eof, e.ip, e.port);
                        end else begin
                            $display("OUT cyc=%0d data=%h eof=%0d ip=%h port=%h ok",
                                     cyc, out_data, out_eof, out_dest_ip, out_dest_port);
                        end
                    end
                    if (out_eof)
                        eof_seen++;
                    in_frame = !out_eof;
                end else if (in_frame) begin
                    bubbles++;
                end
                prev_eof = out_valid && out_eof;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int eof_cyc;
        int ovf_cnt;
        int ovf_word;
        int base_eof;

        rst_n        = 1'b0;
        ch_valid     = '0;
        ch_eof       = '0;
        ch_data      = '0;
        ch_dest_ip   = '0;
        ch_dest_port = '0;
        out_afull    = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_eof", 64'(out_eof), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_ip", 64'(out_dest_ip), 64'd0);
        check("rst_out_port", 64'(out_dest_port), 64'd0);
        check("rst_ch_afull", 64'(ch_afull), 64'd0);
        check("rst_ch_overflow", 64'(ch_overflow), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Four channels commit a 2-word frame in the same cycle: order 0,1,2,3.
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 2; w++)
                expect_word({32'hC0DE0000 + 32'(c), 32'(w)}, (w == 1),
                            32'hC0A80000 + 32'(c), 16'h1000 + 16'(c));
        for (int w = 0; w < 2; w++) begin
            for (int c = 0; c < 4; c++) begin
                ch_valid[c]             = 1'b1;
                ch_eof[c]               = (w == 1);
                ch_data[c*64 +: 64]     = {32'hC0DE0000 + 32'(c), 32'(w)};
                ch_dest_ip[c*32 +: 32]  = 32'hC0A80000 + 32'(c);
                ch_dest_port[c*16 +: 16] = 16'h1000 + 16'(c);
            end
            @(posedge clk); #1;
            ch_valid = '0;
            ch_eof   = '0;
        end
        wait_drain(100);
        send_frame(2, 2, 64'h2200, 32'hC0A80202, 16'h2222);
        wait_drain(100);

        // Single 4-word frame on channel 0 and its eof-to-output latency.
        first_valid_cyc = -1;
        for (int w = 0; w < 4; w++)
            expect_word(64'(w), (w == 3), 32'h0A000001, 16'h1234);
        for (int w = 0; w < 3; w++)
            drive_word(0, 64'(w), 1'b0, 32'h0A000001, 16'h1234);
        eof_cyc = cyc;
        drive_word(0, 64'd3, 1'b1, 32'h0A000001, 16'h1234);
        wait_drain(100);
        check("latency", 64'(first_valid_cyc - eof_cyc), 64'd3);

        // 20-word frame into a 16-word FIFO: one overflow on word 17, no output.
        ovf_cnt  = 0;
        ovf_word = -1;
        for (int w = 0; w < 20; w++) begin
            ch_valid[1]       = 1'b1;
            ch_eof[1]         = (w == 19);
            ch_data[64 +: 64] = 64'h1100 + 64'(w);
            ch_dest_ip[32 +: 32]  = 32'hDEAD0001;
            ch_dest_port[16 +: 16] = 16'hBAD1;
            #3;
            if (ch_overflow[1]) begin
                ovf_cnt++;
                ovf_word = w + 1;
            end
            @(posedge clk); #1;
            ch_valid = '0;
            ch_eof   = '0;
        end
        check("ovf_pulses", 64'(ovf_cnt), 64'd1);
        check("ovf_word", 64'(ovf_word), 64'd17);
        check("ovf_afull_after", 64'(ch_afull[1]), 64'd0);
        send_frame(1, 3, 64'h1500, 32'h0A000101, 16'h0101);
        wait_drain(100);

        // out_afull for 5 cycles mid-frame: exactly 5 bubbles.
        bubbles = 0;
        send_frame(3, 6, 64'hD000, 32'h0A000303, 16'h0303);
        wait_out_valid(50);
        out_afull = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        out_afull = 1'b0;
        wait_drain(100);
        check("afull_bubbles", 64'(bubbles), 64'd5);

        // Reset during the third word of a 6-word frame.
        send_frame(0, 6, 64'hE000, 32'h0A000404, 16'h0404);
        wait_out_valid(50);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_eof", 64'(out_eof), 64'd0);
        check("mid_rst_out_data", out_data, 64'd0);
        check("mid_rst_out_ip", 64'(out_dest_ip), 64'd0);
        check("mid_rst_out_port", 64'(out_dest_port), 64'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("post_rst_afull", 64'(ch_afull), 64'd0);
        @(posedge clk); #1;
        send_frame(0, 3, 64'hE500, 32'h0A000505, 16'h0505);
        wait_drain(100);

        // Ten back-to-back single-word frames on channel 2.
        base_eof = eof_seen;
        for (int k = 0; k < 10; k++)
            expect_word(64'hF0 + 64'(k), 1'b1, 32'h0A000606, 16'h0606);
        for (int k = 0; k < 10; k++)
            drive_word(2, 64'hF0 + 64'(k), 1'b1, 32'h0A000606, 16'h0606);
        wait_drain(200);
        check("single_word_eofs", 64'(eof_seen - base_eof), 64'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
